// File: rtl/cv32e40s_dummy_lfsr.sv
// cv32e40s_dummy_lfsr: Galois LFSR and registered cpuctrl dummy fields feeding the dummy-instruction generator.
module cv32e40s_dummy_lfsr #(
   parameter logic [31:0] LFSR_SEED   = 32'hAC53_3BF4,
   parameter logic [31:0] LFSR_COEFFS = 32'h8000_0057
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_we_i,
   input  logic [31:0] seed_wdata_i,
   input  logic        cpuctrl_we_i,
   input  logic        cpuctrl_rnddummy_i,
   input  logic [3:0]  cpuctrl_rnddummyfreq_i,
   input  logic        shift_i,
   output logic [31:0] lfsr_o,
   output logic        rnddummy_o,
   output logic [3:0]  rnddummyfreq_o,
   output logic        cntrst_o,
   output logic        lockup_o
);
   logic [31:0] lfsr_q, lfsr_d, lfsr_next;
   logic        rnddummy_q, rnddummy_d;
   logic [3:0]  rnddummyfreq_q, rnddummyfreq_d;
   logic        cntrst_q, cntrst_d;
   logic        lockup_q, lockup_d;
   logic        seed_zero, state_zero;

   always_comb begin
      lfsr_next      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_COEFFS : 32'h0);
      seed_zero      = seed_wdata_i == 32'h0;
      state_zero     = lfsr_q == 32'h0;
      // A zero state can only come from a fault; recover it unless a seed write takes precedence.
      lfsr_d         = seed_we_i ? (seed_zero ? LFSR_SEED : seed_wdata_i) :
                       state_zero ? LFSR_SEED : shift_i ? lfsr_next : lfsr_q;
      lockup_d       = seed_we_i ? seed_zero : state_zero;
      cntrst_d       = seed_we_i | cpuctrl_we_i;
      rnddummy_d     = cpuctrl_we_i ? cpuctrl_rnddummy_i : rnddummy_q;
      rnddummyfreq_d = cpuctrl_we_i ? cpuctrl_rnddummyfreq_i : rnddummyfreq_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q         <= LFSR_SEED;
         rnddummy_q     <= 1'b0;
         rnddummyfreq_q <= 4'h0;
         cntrst_q       <= 1'b0;
         lockup_q       <= 1'b0;
      end else begin
         lfsr_q         <= lfsr_d;
         rnddummy_q     <= rnddummy_d;
         rnddummyfreq_q <= rnddummyfreq_d;
         cntrst_q       <= cntrst_d;
         lockup_q       <= lockup_d;
      end
   end

   assign lfsr_o         = lfsr_q;
   assign rnddummy_o     = rnddummy_q;
   assign rnddummyfreq_o = rnddummyfreq_q;
   assign cntrst_o       = cntrst_q;
   assign lockup_o       = lockup_q;
endmodule

// File: tb/tb_cv32e40s_dummy_lfsr.sv
// tb_cv32e40s_dummy_lfsr: scoreboard bench for the dummy-instruction LFSR block.
module tb_cv32e40s_dummy_lfsr;
   localparam logic [31:0] SEED   = 32'hAC53_3BF4;
   localparam logic [31:0] COEFFS = 32'h8000_0057;

   typedef struct packed {
      logic [31:0] lfsr;
      logic        rd;
      logic [3:0]  fq;
      logic        cr;
      logic        lk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seed_we = 1'b0;
   logic [31:0] seed_wdata = 32'h0;
   logic        cpuctrl_we = 1'b0;
   logic        cpuctrl_rd = 1'b0;
   logic [3:0]  cpuctrl_fq = 4'h0;
   logic        shift = 1'b0;
   logic [31:0] lfsr;
   logic        rnddummy;
   logic [3:0]  rnddummyfreq;
   logic        cntrst;
   logic        lockup;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_lfsr = SEED;
   logic        m_rd = 1'b0;
   logic [3:0]  m_fq = 4'h0;

   cv32e40s_dummy_lfsr dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .seed_we_i             (seed_we),
      .seed_wdata_i          (seed_wdata),
      .cpuctrl_we_i          (cpuctrl_we),
      .cpuctrl_rnddummy_i    (cpuctrl_rd),
      .cpuctrl_rnddummyfreq_i(cpuctrl_fq),
      .shift_i               (shift),
      .lfsr_o                (lfsr),
      .rnddummy_o            (rnddummy),
      .rnddummyfreq_o        (rnddummyfreq),
      .cntrst_o              (cntrst),
      .lockup_o              (lockup)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] galois(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ COEFFS;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input logic swe, input logic [31:0] wd, input logic cwe, input logic rd,
                       input logic [3:0] fq, input logic sh);
      exp_t e, o;
      @(negedge clk);
      seed_we = swe; seed_wdata = wd; cpuctrl_we = cwe; cpuctrl_rd = rd; cpuctrl_fq = fq; shift = sh;
      e.lk = swe && wd == 32'h0;
      if (swe) m_lfsr = (wd == 32'h0) ? SEED : wd;
      else if (sh) m_lfsr = galois(m_lfsr);
      if (cwe) begin
         m_rd = rd;
         m_fq = fq;
      end
      e.lfsr = m_lfsr; e.rd = m_rd; e.fq = m_fq; e.cr = swe | cwe;
      sb.push_back(e);
      @(posedge clk);
      #1;
      seed_we = 1'b0; cpuctrl_we = 1'b0; shift = 1'b0;
      o = sb.pop_front();
      chk("lfsr", lfsr, o.lfsr);
      chk("rnddummy", {31'h0, rnddummy}, {31'h0, o.rd});
      chk("rnddummyfreq", {28'h0, rnddummyfreq}, {28'h0, o.fq});
      chk("cntrst", {31'h0, cntrst}, {31'h0, o.cr});
      chk("lockup", {31'h0, lockup}, {31'h0, o.lk});
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_lfsr"}, lfsr, SEED);
      chk({tag, "_rd"}, {31'h0, rnddummy}, 32'h0);
      chk({tag, "_fq"}, {28'h0, rnddummyfreq}, 32'h0);
      chk({tag, "_cr"}, {31'h0, cntrst}, 32'h0);
      chk({tag, "_lk"}, {31'h0, lockup}, 32'h0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      chk_reset("idle");

      step(1'b1, 32'h1, 1'b0, 1'b0, 4'h0, 1'b0);
      chk("seed1", lfsr, 32'h0000_0001);
      chk("seed1_cr", {31'h0, cntrst}, 32'h1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
      chk("shift1", lfsr, 32'h8000_0057);
      chk("shift1_cr", {31'h0, cntrst}, 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
      chk("shift2", lfsr, 32'hC000_007C);

      step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      chk("zseed", lfsr, SEED);
      chk("zseed_lk", {31'h0, lockup}, 32'h1);
      chk("zseed_cr", {31'h0, cntrst}, 32'h1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      chk("zseed_lk_end", {31'h0, lockup}, 32'h0);

      step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 1'b1);
      chk("seed_shift", lfsr, 32'h1234_5678);

      step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0);
      chk("cpu1_rd", {31'h0, rnddummy}, 32'h1);
      chk("cpu1_fq", {28'h0, rnddummyfreq}, 32'hF);
      step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0);
      chk("cpu2_rd", {31'h0, rnddummy}, 32'h0);
      chk("cpu2_cr", {31'h0, cntrst}, 32'h1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      chk("cpu_cr_end", {31'h0, cntrst}, 32'h0);

      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
      chk("three_shifts", lfsr, galois(galois(galois(32'h1234_5678))));

      for (int i = 0; i < 60; i++) begin
         logic [31:0] wd;
         wd = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         step($urandom_range(0, 5) == 0, wd, $urandom_range(0, 5) == 0, 1'($urandom),
              4'($urandom), 1'($urandom));
      end

      step(1'b1, 32'h0, 1'b1, 1'b1, 4'h5, 1'b0);
      chk("pre_rst_lk", {31'h0, lockup}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      m_lfsr = SEED; m_rd = 1'b0; m_fq = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
      chk("post_rst_shift", lfsr, galois(SEED));
      chk("sb_empty", sb.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
